wb_program_loader: RTL

//  Wishbone classic master that sits directly upstream of the memory controller top.

---
 rtl/wb_program_loader_if.sv | 38 +++
 rtl/wb_program_loader.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_program_loader_if.sv
`default_nettype none
// ============================================================================
//  Module   : wb_program_loader_if
//  Purpose  : Bundles the program-word source handshake and the Wishbone
//             classic bus seen by wb_program_loader.
//  Signals  : src_valid/src_data/src_ready  - valid/ready word source
//             cyc_o/stb_o/we_o/adr_o/dat_o   - Wishbone master outputs
//             dat_i/ack_i                    - Wishbone slave responses
//  Modports : master - the loader's view
//             slave  - the source + memory side view
//  Revision : 1.0  initial release
// ============================================================================
interface wb_program_loader_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) ();
  logic              src_valid;
  logic [DATA_W-1:0] src_data;
  logic              src_ready;
  logic              cyc_o;
  logic              stb_o;
  logic              we_o;
  logic [ADDR_W-1:0] adr_o;
  logic [DATA_W-1:0] dat_o;
  logic [DATA_W-1:0] dat_i;
  logic              ack_i;

  modport master (
    input  src_valid, src_data, dat_i, ack_i,
    output src_ready, cyc_o, stb_o, we_o, adr_o, dat_o
  );

  modport slave (
    output src_valid, src_data, dat_i, ack_i,
    input  src_ready, cyc_o, stb_o, we_o, adr_o, dat_o
  );
endinterface
`default_nettype wire

// File: rtl/wb_program_loader.sv
`default_nettype none
// ============================================================================
//  Module   : wb_program_loader
//  Purpose  : Wishbone classic master that copies NUM_WORDS program words
//             from a valid/ready source into memory at BASE_ADDR+i, reads the
//             region back, compares running sums, and on a match hands the
//             memory to the core via core_select.
//  Ports    : clk         - system clock, rising edge
//             reset       - asynchronous, active-high
//             start       - 1-cycle pulse, accepted in IDLE/DONE/ERROR
//             bus         - source handshake + Wishbone master (interface)
//             core_select - 0 = loader owns memory, 1 = core owns memory
//             busy        - high in FETCH/WRITE/READ/CHECK
//             done        - high in DONE (verified load)
//             error       - high in ERROR, cleared by start or reset
//  Revision : 1.0  initial release
// ============================================================================
module wb_program_loader #(
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                NUM_WORDS = 100,
  parameter int                TIMEOUT   = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  wb_program_loader_if.master   bus,
  output logic                  core_select,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_READ  = 3'd3;
  localparam logic [2:0] S_CHECK = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_ERROR = 3'd6;

  localparam int              IDX_W    = 16;
  localparam int              TMO_W    = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  logic [2:0]        state_q,       state_d;
  logic [IDX_W-1:0]  idx_q,         idx_d;
  logic [DATA_W-1:0] wr_sum_q,      wr_sum_d;
  logic [DATA_W-1:0] rd_sum_q,      rd_sum_d;
  logic [TMO_W-1:0]  tmo_q,         tmo_d;
  logic              cyc_q,         cyc_d;
  logic              stb_q,         stb_d;
  logic              we_q,          we_d;
  logic [ADDR_W-1:0] adr_q,         adr_d;
  logic [DATA_W-1:0] dat_q,         dat_d;
  logic              core_select_q, core_select_d;

  logic              w_xfer;
  logic              w_stall;
  logic              w_last;
  logic [ADDR_W-1:0] w_cur_adr;

  // A transfer completes only while the strobe is up; stray acks are ignored.
  assign w_xfer    = stb_q & bus.ack_i;
  assign w_stall   = stb_q & ~bus.ack_i;
  assign w_last    = (idx_q == LAST_IDX);
  assign w_cur_adr = BASE_ADDR + ADDR_W'(idx_q);

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    wr_sum_d      = wr_sum_q;
    rd_sum_d      = rd_sum_q;
    tmo_d         = tmo_q;
    cyc_d         = cyc_q;
    stb_d         = stb_q;
    we_d          = we_q;
    adr_d         = adr_q;
    dat_d         = dat_q;
    core_select_d = core_select_q;

    unique case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d       = S_FETCH;
          idx_d         = '0;
          wr_sum_d      = '0;
          rd_sum_d      = '0;
          tmo_d         = '0;
          cyc_d         = 1'b1;
          stb_d         = 1'b0;
          we_d          = 1'b0;
          core_select_d = 1'b0;
        end
      end

      S_FETCH: begin
        // Latch the word and strobe on the next cycle; the FETCH cycle itself
        // provides the mandatory strobe-low gap between writes.
        if (bus.src_valid) begin
          dat_d    = bus.src_data;
          adr_d    = w_cur_adr;
          wr_sum_d = wr_sum_q + bus.src_data;
          stb_d    = 1'b1;
          we_d     = 1'b1;
          state_d  = S_WRITE;
        end
      end

      S_WRITE: begin
        if (w_xfer) begin
          stb_d = 1'b0;
          tmo_d = '0;
          if (w_last) begin
            idx_d   = '0;
            we_d    = 1'b0;
            state_d = S_READ;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_FETCH;
          end
        end
      end

      S_READ: begin
        if (!stb_q) begin
          // Strobe-low cycle after every completed transfer, then re-strobe.
          stb_d = 1'b1;
          we_d  = 1'b0;
          adr_d = w_cur_adr;
        end else if (bus.ack_i) begin
          rd_sum_d = rd_sum_q + bus.dat_i;
          stb_d    = 1'b0;
          tmo_d    = '0;
          if (w_last) begin
            cyc_d   = 1'b0;
            state_d = S_CHECK;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      S_CHECK: begin
        if (wr_sum_q == rd_sum_q) begin
          core_select_d = 1'b1;
          state_d       = S_DONE;
        end else begin
          state_d = S_ERROR;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Slave watchdog overrides the normal flow: after TIMEOUT unacknowledged
    // strobe cycles the bus is released and the load is abandoned.
    if (w_stall) begin
      if (tmo_q == TMO_LAST) begin
        state_d       = S_ERROR;
        cyc_d         = 1'b0;
        stb_d         = 1'b0;
        we_d          = 1'b0;
        core_select_d = 1'b0;
        tmo_d         = '0;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      wr_sum_q      <= '0;
      rd_sum_q      <= '0;
      tmo_q         <= '0;
      cyc_q         <= 1'b0;
      stb_q         <= 1'b0;
      we_q          <= 1'b0;
      adr_q         <= '0;
      dat_q         <= '0;
      core_select_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      wr_sum_q      <= wr_sum_d;
      rd_sum_q      <= rd_sum_d;
      tmo_q         <= tmo_d;
      cyc_q         <= cyc_d;
      stb_q         <= stb_d;
      we_q          <= we_d;
      adr_q         <= adr_d;
      dat_q         <= dat_d;
      core_select_q <= core_select_d;
    end
  end

  assign bus.src_ready = (state_q == S_FETCH);
  assign bus.cyc_o     = cyc_q;
  assign bus.stb_o     = stb_q;
  assign bus.we_o      = we_q;
  assign bus.adr_o     = adr_q;
  assign bus.dat_o     = dat_q;

  assign core_select = core_select_q;
  assign done        = (state_q == S_DONE);
  assign error       = (state_q == S_ERROR);
  assign busy        = (state_q == S_FETCH) | (state_q == S_WRITE) |
                       (state_q == S_READ)  | (state_q == S_CHECK);

endmodule
`default_nettype wire
